// File: rtl/alu_mc.sv
// Multi-cycle ALU: simple ops complete in one cycle, MUL/MULHU/DIVU/REMU iterate
// one bit per cycle over a shared 2*WIDTH accumulator behind a valid/ready handshake.
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [WIDTH-1:0]     simple_res, iter_res;
    logic [WIDTH:0]       mul_sum, div_sh, div_diff;
    logic                 div_ge, is_mul, op_iter, accept, last_step;

    assign op_iter   = (op >= 4'd11) && (op <= 4'd14);
    assign is_mul    = (op_q == 4'd11) || (op_q == 4'd12);
    assign accept    = in_valid && in_ready;
    assign last_step = (state == BUSY) && (cnt == CW'(1));

    always_comb begin
        simple_res = A;
        case (op)
            4'd1:  simple_res = A + B;
            4'd2:  simple_res = A - B;
            4'd3:  simple_res = A & B;
            4'd4:  simple_res = A | B;
            4'd5:  simple_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'd6:  simple_res = {{(WIDTH-1){1'b0}}, A < B};
            4'd7:  simple_res = B << shamt;
            4'd8:  simple_res = B >> shamt;
            4'd9:  simple_res = WIDTH'($signed(B) >>> shamt);
            4'd10: simple_res = A ^ B;
            default: simple_res = A;
        endcase
    end

    // acc is {high/remainder, low/quotient}; opnd holds multiplicand or divisor.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_sh   = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = div_sh >= {1'b0, opnd};
        div_diff = div_sh - {1'b0, opnd};
        if (is_mul)
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        else
            acc_nxt = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end

    // MUL and DIVU take the low half, MULHU and REMU the high half.
    assign iter_res = op_q[0] ? acc_nxt[WIDTH-1:0] : acc_nxt[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = op_iter ? BUSY : DONE;
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) state_nxt = op_iter ? BUSY : DONE;
                    else          state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            op_q <= '0;
            opnd <= '0;
            acc  <= '0;
            C    <= '0;
            zero <= 1'b1;
        end else if (accept) begin
            if (op_iter) begin
                op_q <= op;
                cnt  <= CW'(WIDTH);
                if ((op == 4'd11) || (op == 4'd12)) begin
                    opnd <= A;
                    acc  <= {{WIDTH{1'b0}}, B};
                end else begin
                    opnd <= B;
                    acc  <= {{WIDTH{1'b0}}, A};
                end
            end else begin
                C    <= simple_res;
                zero <= (simple_res == '0);
            end
        end else if (state == BUSY) begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
            if (last_step) begin
                C    <= iter_res;
                zero <= (iter_res == '0);
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=32 and WIDTH=8 with a result scoreboard.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sel;
    logic        in_valid, out_ready;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic [3:0]  op;

    logic        iv32, iv8;
    logic        in_ready32, out_valid32, zero32, busy32;
    logic        in_ready8, out_valid8, zero8, busy8;
    logic [31:0] c32;
    logic [7:0]  c8;

    logic        in_ready, out_valid, zero, busy;
    logic [31:0] c;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    assign iv32 = in_valid & ~sel;
    assign iv8  = in_valid & sel;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .rstn(rstn), .in_valid(iv32), .in_ready(in_ready32),
        .A(a), .B(b), .shamt(shamt), .op(op),
        .out_valid(out_valid32), .out_ready(out_ready),
        .C(c32), .zero(zero32), .busy(busy32)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rstn(rstn), .in_valid(iv8), .in_ready(in_ready8),
        .A(a[7:0]), .B(b[7:0]), .shamt(shamt[2:0]), .op(op),
        .out_valid(out_valid8), .out_ready(out_ready),
        .C(c8), .zero(zero8), .busy(busy8)
    );

    always_comb begin
        in_ready  = sel ? in_ready8  : in_ready32;
        out_valid = sel ? out_valid8 : out_valid32;
        zero      = sel ? zero8      : zero32;
        busy      = sel ? busy8      : busy32;
        c         = sel ? {24'h0, c8} : c32;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh, input logic [31:0] exp);
        in_valid = 1'b1;
        op = o; a = av; b = bv; shamt = sh;
        sb.push_back(exp);
    endtask

    task automatic check_result(input string tag);
        logic [31:0] e;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=result expected=empty scoreboard", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_c"}, c, e);
            chk({tag, "_zero"}, 32'(zero), 32'(e == 32'h0));
        end
    endtask

    task automatic run_iter(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] exp, input string tag);
        int n;
        bit ok;
        int w;
        w = sel ? 8 : 32;
        drive(o, av, bv, 5'd0, exp);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        ok = 1'b1;
        while (!out_valid && n < 200) begin
            if (!busy || in_ready) ok = 1'b0;
            n++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(n), 32'(w));
        chk({tag, "_busy_hold"}, 32'(ok), 32'd1);
        check_result(tag);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        sel = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; shamt = '0; op = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_c", c, 32'h0);
        chk("rst_zero", 32'(zero), 32'd1);
        rstn = 1'b1;
        @(negedge clk);

        // back-to-back simple ops
        drive(4'd1, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000);
        @(negedge clk); check_result("add");
        drive(4'd2, 32'h5, 32'h5, 5'd0, 32'h0);
        @(negedge clk); check_result("sub");
        drive(4'd5, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1);
        @(negedge clk); check_result("slt");
        drive(4'd6, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0);
        @(negedge clk); check_result("sltu");
        drive(4'd9, 32'h0, 32'h80000000, 5'd4, 32'hF8000000);
        @(negedge clk); check_result("sra");
        drive(4'd8, 32'h0, 32'h80000000, 5'd4, 32'h08000000);
        @(negedge clk); check_result("srl");
        drive(4'd10, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'hF00FF00F);
        @(negedge clk); check_result("xor");
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_after_ops", 32'(out_valid), 32'd0);

        run_iter(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul");
        run_iter(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        run_iter(4'd13, 32'd100, 32'd7, 32'd14, "divu");
        run_iter(4'd14, 32'd100, 32'd7, 32'd2, "remu");
        run_iter(4'd13, 32'h1234, 32'h0, 32'hFFFFFFFF, "divu0");
        run_iter(4'd14, 32'h1234, 32'h0, 32'h00001234, "remu0");
        @(negedge clk);

        // backpressure: result held while out_ready is low
        out_ready = 1'b0;
        drive(4'd4, 32'hF0F00000, 32'h00001234, 5'd0, 32'hF0F01234);
        @(negedge clk);
        in_valid = 1'b0;
        check_result("or_bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_c", c, 32'hF0F01234);
            chk("bp_zero", 32'(zero), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        drive(4'd1, 32'd2, 32'd3, 5'd0, 32'd5);
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_result("add_bp");
        @(negedge clk);
        chk("bp_idle", 32'(out_valid), 32'd0);

        // reset in the middle of a divide
        in_valid = 1'b1; op = 4'd13; a = 32'd100; b = 32'd7; shamt = '0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        chk("mid_div_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_c", c, 32'h0);
        chk("mid_rst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        drive(4'd1, 32'h10, 32'h20, 5'd0, 32'h30);
        @(negedge clk);
        in_valid = 1'b0;
        check_result("add_post_rst");
        @(negedge clk);

        // WIDTH=8 instance
        sel = 1'b1;
        run_iter(4'd11, 32'hFF, 32'hFF, 32'h01, "mul8");
        run_iter(4'd12, 32'hFF, 32'hFF, 32'hFE, "mulhu8");
        drive(4'd7, 32'h0, 32'h01, 5'd7, 32'h80);
        @(negedge clk);
        in_valid = 1'b0;
        check_result("sll8");
        @(negedge clk);
        chk("idle8", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
